// File: rtl/mem_dump_streamer.sv
// Reads a window of word-addressed memory and streams it out over valid/ready.
// Optional `DUMP_CHECKSUM_EN appends a wrap-around sum word after the data words.
module mem_dump_streamer #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   word_count_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_en_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {StIdle, StRead, StWait, StSend, StFin} state_e;

    localparam logic [ADDR_W:0] CntOne = (ADDR_W+1)'(1);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     cnt_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic                mem_rd_en_q;
    logic                busy_q;
    logic                done_q;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q;
    logic                chk_q;  // the word in SEND is the checksum, not data
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            mem_rd_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            sum_q       <= '0;
            chk_q       <= 1'b0;
`endif
        end else begin
            mem_rd_en_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        addr_q <= base_addr_i;
                        cnt_q  <= word_count_i;
                        busy_q <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        sum_q  <= '0;
                        chk_q  <= 1'b0;
`endif
                        if (word_count_i == '0) begin
`ifdef DUMP_CHECKSUM_EN
                            out_data_q  <= '0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b1;
                            chk_q       <= 1'b1;
                            state_q     <= StSend;
`else
                            done_q  <= 1'b1;
                            state_q <= StFin;
`endif
                        end else begin
                            mem_rd_en_q <= 1'b1;
                            state_q     <= StRead;
                        end
                    end
                end
                StRead: state_q <= StWait;
                StWait: begin
                    out_data_q  <= mem_rdata_i;
                    out_valid_q <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    out_last_q  <= 1'b0;
`else
                    out_last_q  <= (cnt_q == CntOne);
`endif
                    state_q     <= StSend;
                end
                StSend: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                        if (chk_q) begin
                            done_q  <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                            cnt_q  <= cnt_q - 1'b1;
                            sum_q  <= sum_q + out_data_q;
                            if (cnt_q == CntOne) begin
                                // Sum word goes straight back into SEND, no memory read
                                out_data_q  <= sum_q + out_data_q;
                                out_valid_q <= 1'b1;
                                out_last_q  <= 1'b1;
                                chk_q       <= 1'b1;
                            end else begin
                                mem_rd_en_q <= 1'b1;
                                state_q     <= StRead;
                            end
                        end
`else
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q - 1'b1;
                        if (cnt_q == CntOne) begin
                            done_q  <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            mem_rd_en_q <= 1'b1;
                            state_q     <= StRead;
                        end
`endif
                    end
                end
                StFin: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_rd_en_o = mem_rd_en_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Directed bench for mem_dump_streamer with a synchronous-read memory model.
// Covers both builds of DUMP_CHECKSUM_EN.
module tb_mem_dump_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] word_count;
    logic [9:0]  mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] mem [0:1023];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    mem_dump_streamer #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .base_addr_i (base_addr),
        .word_count_i(word_count),
        .mem_addr_o  (mem_addr),
        .mem_rd_en_o (mem_rd_en),
        .mem_rdata_i (mem_rdata),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_last_o  (out_last),
        .busy_o      (busy),
        .done_o      (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is sampled by the next posedge only.
    task automatic start_dump(input logic [9:0] b, input logic [10:0] n);
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Steps negedges until out_valid; checks latency, data, last and the read address.
    task automatic expect_word(input string tag, input logic [31:0] d, input logic l,
                               input int exp_wait, input logic [9:0] a, input bit chk_addr);
        int          waits = 0;
        logic [9:0]  seen  = '0;
        do begin
            @(negedge clk);
            waits++;
            if (mem_rd_en) seen = mem_addr;
        end while (!out_valid && waits < 20);
        chk({tag, " valid"}, 64'(out_valid), 64'd1);
        chk({tag, " wait"}, 64'(waits), 64'(exp_wait));
        chk({tag, " data"}, 64'(out_data), 64'(d));
        chk({tag, " last"}, 64'(out_last), 64'(l));
        if (chk_addr) chk({tag, " addr"}, 64'(seen), 64'(a));
    endtask

    task automatic expect_done(input string tag);
        @(negedge clk);
        chk({tag, " done"}, {62'd0, done, busy}, 64'b11);
        chk({tag, " valid off"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, " idle"}, {62'd0, done, busy}, 64'b00);
    endtask

    initial begin
`ifdef DUMP_CHECKSUM_EN
        localparam bit Ck = 1'b1;
`else
        localparam bit Ck = 1'b0;
`endif
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
        mem[1022] = 32'hA; mem[1023] = 32'hB;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1;
        #12;
        chk("reset outputs", {out_data, 10'd0, mem_addr, out_valid, out_last, mem_rd_en,
                              busy, done}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Test 1: four words, ready held high
        start_dump(10'd0, 11'd4);
        expect_word("t1 w1", 32'd1, 1'b0, 3, 10'd0, 1'b1);
        chk("t1 busy", 64'(busy), 64'd1);
        expect_word("t1 w2", 32'd2, 1'b0, 3, 10'd1, 1'b1);
        expect_word("t1 w3", 32'd3, 1'b0, 3, 10'd2, 1'b1);
        expect_word("t1 w4", 32'd4, !Ck, 3, 10'd3, 1'b1);
        if (Ck) expect_word("t1 sum", 32'd10, 1'b1, 1, 10'd0, 1'b0);
        expect_done("t1");

        // Test 2: stall on word 2; a stray start while busy must be ignored
        start_dump(10'd0, 11'd4);
        expect_word("t2 w1", 32'd1, 1'b0, 3, 10'd0, 1'b1);
        expect_word("t2 w2", 32'd2, 1'b0, 3, 10'd1, 1'b1);
        out_ready = 1'b0;
        start = 1'b1; base_addr = 10'd500; word_count = 11'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2 stall hold", {30'd0, out_data, out_valid, mem_rd_en}, {30'd0, 32'd2, 2'b10});
        end
        start = 1'b0;
        out_ready = 1'b1;
        expect_word("t2 w3", 32'd3, 1'b0, 3, 10'd2, 1'b1);
        expect_word("t2 w4", 32'd4, !Ck, 3, 10'd3, 1'b1);
        if (Ck) expect_word("t2 sum", 32'd10, 1'b1, 1, 10'd0, 1'b0);
        expect_done("t2");

        // Test 3: address wrap from the top of memory
        mem[0] = 32'hC; mem[1] = 32'hD;
        start_dump(10'd1022, 11'd4);
        expect_word("t3 w1", 32'hA, 1'b0, 3, 10'd1022, 1'b1);
        expect_word("t3 w2", 32'hB, 1'b0, 3, 10'd1023, 1'b1);
        expect_word("t3 w3", 32'hC, 1'b0, 3, 10'd0, 1'b1);
        expect_word("t3 w4", 32'hD, !Ck, 3, 10'd1, 1'b1);
        if (Ck) expect_word("t3 sum", 32'h2E, 1'b1, 1, 10'd0, 1'b0);
        expect_done("t3");
        mem[0] = 32'd1; mem[1] = 32'd2;

        // Test 4: zero-length dump
        start_dump(10'd7, 11'd0);
`ifdef DUMP_CHECKSUM_EN
        expect_word("t4 sum", 32'd0, 1'b1, 1, 10'd0, 1'b0);
        expect_done("t4");
`else
        @(negedge clk);
        chk("t4 done", {61'd0, done, busy, out_valid}, 64'b110);
        @(negedge clk);
        chk("t4 idle", {61'd0, done, busy, out_valid}, 64'b000);
`endif

        // Test 5: asynchronous reset after word 1, then a fresh dump
        start_dump(10'd0, 11'd4);
        expect_word("t5 w1", 32'd1, 1'b0, 3, 10'd0, 1'b1);
        @(negedge clk);
        chk("t5 reading", {62'd0, mem_rd_en, busy}, 64'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 async reset", {out_data, 10'd0, mem_addr, out_valid, out_last, mem_rd_en,
                               busy, done}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("t5 no done", 64'(done), 64'd0);
        start_dump(10'd2, 11'd2);
        expect_word("t5 w3", 32'd3, 1'b0, 3, 10'd2, 1'b1);
        expect_word("t5 w4", 32'd4, !Ck, 3, 10'd3, 1'b1);
        if (Ck) expect_word("t5 sum", 32'd7, 1'b1, 1, 10'd0, 1'b0);
        expect_done("t5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
